// File: rtl/tx_frame_pkg.sv
// rtl/tx_frame_pkg.sv - shared types and constants for the serial transmit frame controller
//
// Holds the FSM state type, frame constants and the helper that builds the
// parallel frame image loaded into the shift register.
// Optional feature: define TX_FRAME_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frame instead of 10).
package tx_frame_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef TX_FRAME_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    // The stop bit is never loaded: it is supplied by the 1s fill on shift.
    localparam int SHIFT_BITS = FRAME_BITS - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef TX_FRAME_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // Frame image with the start bit in bit 0 so it leaves the line first.
    function automatic logic [SHIFT_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
`ifdef TX_FRAME_PARITY_EN
        return {^data, data, START_BIT};
`else
        return {data, START_BIT};
`endif
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// rtl/tx_shift_reg.sv - LSB-first frame shift register with 1s fill
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : parallel load of load_data (takes priority over shift)
//   load_data    : frame image, bit 0 transmitted first
//   shift_en     : shift right by one at a bit boundary, filling with 1s
//   ser_out      : bit 0 of the register, a flop output (idle/stop level when empty)
module tx_shift_reg
    import tx_frame_pkg::*;
#(
    parameter int WIDTH = SHIFT_BITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out
);

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shift_q;

    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = load_data;
        end else if (shift_en) begin
            shift_d = {STOP_BIT, shift_q[WIDTH-1:1]};
        end
    end

    // Reset fills with the idle level so the line goes high the moment reset asserts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= {WIDTH{IDLE_LEVEL}};
        end else begin
            shift_q <= shift_d;
        end
    end

    assign ser_out = shift_q[0];

endmodule

// File: rtl/tx_frame_ctrl.sv
// rtl/tx_frame_ctrl.sv - serial transmit frame controller (start, 8 data LSB first, stop)
//
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   tx_data   : byte to send, captured on accept (tx_valid && tx_ready)
//   tx_valid  : requester has a byte
//   tx_ready  : high only in IDLE
//   tx_out    : serial line, idle high, driven straight from a flop
//   tx_busy   : frame in progress
//   tx_done   : one-cycle pulse on the first IDLE cycle after STOP
// Parameter CLKS_PER_BIT (2..65535) sets clock cycles per serial bit.
// Optional feature: define TX_FRAME_PARITY_EN for an even-parity bit before STOP.
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int              BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_e        state_d,   state_q;
    logic [CNT_W-1:0] cnt_d,     cnt_q;
    logic [BIT_W-1:0] bit_idx_d, bit_idx_q;
    logic             ready_d,   ready_q;
    logic             busy_d,    busy_q;
    logic             done_d,    done_q;

    logic accept;
    logic bit_end;
    logic shift_en;

    assign accept  = tx_valid && ready_q;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shift_en  = 1'b0;

        // Baud counter runs in every bit-holding state and wraps at the boundary.
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    shift_en  = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef TX_FRAME_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef TX_FRAME_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    shift_en = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // The register has already drained to 1s, so no shift is needed here.
                if (bit_end) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Loading on accept puts the start bit on the line at the same edge the FSM enters START.
    tx_shift_reg #(
        .WIDTH(SHIFT_BITS)
    ) u_shift (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .load_data (build_frame(tx_data)),
        .shift_en  (shift_en),
        .ser_out   (tx_out)
    );

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb/tb_tx_frame_ctrl.sv - directed self-checking bench for tx_frame_ctrl at N=4, 16 and 2
module tb_tx_frame_ctrl;

    localparam int N0 = 4;
    localparam int N1 = 16;
    localparam int N2 = 2;
`ifdef TX_FRAME_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] out;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] data [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_frame_ctrl #(.CLKS_PER_BIT(N0)) u_dut_n4 (
        .clk(clk), .reset_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    tx_frame_ctrl #(.CLKS_PER_BIT(N1)) u_dut_n16 (
        .clk(clk), .reset_n(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    tx_frame_ctrl #(.CLKS_PER_BIT(N2)) u_dut_n2 (
        .clk(clk), .reset_n(rst_n[2]), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed {tx_out, tx_ready, tx_busy, tx_done}.
    function automatic logic [3:0] obs(input int idx);
        return {out[idx], ready[idx], busy[idx], done[idx]};
    endfunction

    // Expected line level per bit slot: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef TX_FRAME_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // Entered at a negedge with the DUT idle. mode 0: drop valid after accept;
    // mode 1: keep valid high and present nxt; mode 2: scramble inputs mid-frame.
    // Returns at the negedge of the tx_done cycle.
    task automatic send_frame(input int idx, input int n, input logic [7:0] b,
                              input int mode, input logic [7:0] nxt, input string tag);
        logic [10:0] fr;
        fr         = frame_bits(b);
        valid[idx] = 1'b1;
        data[idx]  = b;
        @(posedge clk);
        #1;
        case (mode)
            0:       valid[idx] = 1'b0;
            1:       data[idx]  = nxt;
            default: begin
                valid[idx] = 1'($urandom);
                data[idx]  = 8'($urandom);
            end
        endcase
        for (int k = 0; k < FB * n; k++) begin
            @(negedge clk);
            chk($sformatf("%s cyc%0d", tag, k), obs(idx), {fr[k / n], 3'b010});
            if (mode == 2) begin
                if (k == FB * n - 1) begin
                    valid[idx] = 1'b0;
                end else begin
                    valid[idx] = 1'($urandom);
                    data[idx]  = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        chk($sformatf("%s done_cycle", tag), obs(idx), 4'b1101);
    endtask

    initial begin
        rst_n = 3'b000;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("reset_state%0d", i), obs(i), 4'b1100);
        rst_n = 3'b111;

        // First accept right after reset release, 0x55 at N=4.
        send_frame(0, N0, 8'h55, 0, 8'h00, "n4_55");
        @(negedge clk);
        chk("n4_55 idle_after", obs(0), 4'b1100);

        // Back-to-back with valid held: 0xA3 then 0x0F, one idle-high cycle between.
        send_frame(0, N0, 8'hA3, 1, 8'h0F, "n4_a3");
        send_frame(0, N0, 8'h0F, 0, 8'h00, "n4_0f");
        @(negedge clk);
        chk("n4_0f idle_after", obs(0), 4'b1100);

        // Inputs scrambled mid-frame must not alter the captured byte.
        send_frame(0, N0, 8'h9C, 2, 8'h00, "n4_scr");
        @(negedge clk);
        chk("n4_scr idle_after", obs(0), 4'b1100);

        // N=16: abort a 0x00 frame around cycle 50 with an asynchronous reset.
        valid[1] = 1'b1;
        data[1]  = 8'h00;
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        repeat (50) @(negedge clk);
        chk("n16 mid_frame", obs(1), 4'b0010);
        #2;
        rst_n[1] = 1'b0;
        #1;
        chk("n16 async_reset", obs(1), 4'b1100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("n16 in_reset%0d", i), obs(1), 4'b1100);
        end
        rst_n[1] = 1'b1;
        send_frame(1, N1, 8'hC4, 0, 8'h00, "n16_c4");
        @(negedge clk);
        chk("n16_c4 idle_after", obs(1), 4'b1100);

        // Minimum N=2.
        send_frame(2, N2, 8'hFF, 0, 8'h00, "n2_ff");
        @(negedge clk);
        chk("n2_ff idle_after", obs(2), 4'b1100);
        send_frame(2, N2, 8'h07, 0, 8'h00, "n2_07");
        @(negedge clk);
        chk("n2_07 idle_after", obs(2), 4'b1100);
        send_frame(2, N2, 8'h03, 0, 8'h00, "n2_03");
        @(negedge clk);
        chk("n2_03 idle_after", obs(2), 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  input  1  single system clock, all logic on rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  tx_data  input  8  byte to transmit, sampled only on accept.
  tx_valid  input  1  requester has a byte.
  tx_ready  output  1  block can accept; accept = tx_valid && tx_ready at a rising clk edge.
  tx_out  output  1  serial line, idle high.
  tx_busy  output  1  frame in progress.
  tx_done  output  1  one-cycle pulse at frame completion.
REQ-003 SHALL use one clock; reset is asynchronous and active-low, on port reset_n.

Function
REQ-004 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-005 IDLE: tx_ready=1, tx_busy=0, tx_out=1; on accept, SHALL capture tx_data and enter START at the next edge.
REQ-006 START: tx_out=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-007 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; bit index counts 0..7, then enter PARITY (macro) or STOP.
REQ-008 STOP: tx_out=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-009 tx_done SHALL pulse high for exactly one cycle: the first IDLE cycle after STOP.
REQ-010 Timing: with an accept at edge 0, the start bit SHALL appear from edge 0 to edge N (N=CLKS_PER_BIT), and tx_ready SHALL be high again after edge 10N (11N with macro).
REQ-011 tx_ready SHALL be 0 and tx_busy 1 in every non-IDLE state.
REQ-012 tx_valid and tx_data SHALL be ignored outside IDLE; input changes mid-frame SHALL not alter the frame.
REQ-013 Back-to-back: a tx_valid held high SHALL be accepted in the tx_done cycle, leaving exactly one idle-high cycle between frames.
REQ-014 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..N-1, and wrap to 0 at each bit boundary; there SHALL be no glitches on tx_out between boundaries.
REQ-015 tx_out SHALL be registered, with no combinational path from inputs to tx_out.

Reset
REQ-016 reset_n low SHALL force, immediately and asynchronously: state IDLE, tx_out=1, tx_ready=1 after release, tx_busy=0, tx_done=0, counters=0.
REQ-017 Reset mid-frame SHALL abort the frame, with no tx_done pulse; the line SHALL return high immediately.
REQ-018 The first accept SHALL be possible at the first edge after reset_n deasserts.

Configuration
REQ-019 With macro TX_FRAME_PARITY_EN defined, the PARITY state SHALL send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving an 11-bit frame.
REQ-020 Without TX_FRAME_PARITY_EN, the PARITY state and its logic SHALL be absent, giving a 10-bit frame.

Structure
REQ-021 Shared package tx_frame_pkg SHALL hold: the state enum type; DATA_BITS=8; START_BIT=1'b0; STOP_BIT=1'b1; IDLE_LEVEL=1'b1.
REQ-022 Sub-module tx_shift_reg SHALL handle parallel load of the captured frame, LSB-first shift on a bit-boundary enable, and fill with 1s; the FSM and baud counter stay in tx_frame_ctrl.

Verification
REQ-023 N=4, accept 0x55 -> tx_out 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_ready low 40 cycles; one tx_done pulse.
REQ-024 N=4, tx_valid held high with 0xA3 then 0x0F -> two frames (0xA3 bits 1,1,0,0,0,1,0,1 after start), separated by exactly one idle-high cycle.
REQ-025 N=16, reset_n pulsed low at cycle 50 of a 0x00 frame -> tx_out=1 within the reset cycle, no tx_done, next accept sends a clean frame.
REQ-026 N=4, tx_data changed and tx_valid toggled during a frame -> transmitted bits match the value captured at accept.
REQ-027 TX_FRAME_PARITY_EN, N=2: 0x07 -> parity bit 1; 0x03 -> parity bit 0; tx_ready returns after 22 cycles.
REQ-028 N=2 (minimum) with 0xFF -> start low 2 cycles, then line high 18 cycles; counter wrap checked at every boundary.
